// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Turns a PLL lock indication into a set of staggered, per-domain resets.
// The asynchronous lock signal is synchronised, must stay high for a
// programmable run of consecutive cycles, and then the reset domains are
// released one at a time (bit 0 first: interconnect, then CPU, then
// peripherals). Losing lock or a software request reasserts every domain
// at once and restarts the whole sequence. Lock-loss aborts are counted.
//
// Parameters:
//   SYNC_STAGES  flops in the locked_async synchroniser (2..4)
//   HOLD_CYCLES  consecutive synchronised-locked cycles before first release
//   NUM_RESETS   number of reset domains (1..8)
//   STAGE_GAP    cycles between successive domain releases (1..255)
//
// Ports:
//   clk              PLL output clock
//   reset            asynchronous active-high power-on/external reset
//   locked_async     PLL lock, asynchronous to clk
//   sw_reset_req     single-cycle synchronous request to re-run the sequence
//   resets_out       per-domain active-high reset, bit 0 released first
//   ready            high when every domain is released
//   lock_loss_count  saturating count of lock-loss aborts since reset
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 15,
  parameter int NUM_RESETS  = 3,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  locked_async,
  input  logic                  sw_reset_req,
  output logic [NUM_RESETS-1:0] resets_out,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(NUM_RESETS - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;
  logic                   abort;

  state_t                 state_reg, state_next;
  logic [15:0]            hold_reg, hold_next;
  logic [7:0]             gap_reg, gap_next;
  logic [3:0]             idx_reg, idx_next;
  logic [NUM_RESETS-1:0]  resets_reg, resets_next;
  logic                   ready_reg, ready_next;
  logic [7:0]             count_reg, count_next;
  logic [NUM_RESETS-1:0]  stage_sel;

  // Plain shift-register synchroniser; only its last stage is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked_async};
    end
  end

  assign locked_s = sync_reg[SYNC_STAGES-1];
  assign abort    = ~locked_s | sw_reset_req;

  // One-hot select of the domain released next in RELEASE.
  for (genvar gi = 0; gi < NUM_RESETS; gi++) begin : g_sel
    assign stage_sel[gi] = (idx_reg == 4'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_HOLD;
      hold_reg   <= '0;
      gap_reg    <= '0;
      idx_reg    <= '0;
      resets_reg <= '1;
      ready_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      gap_reg    <= gap_next;
      idx_reg    <= idx_next;
      resets_reg <= resets_next;
      ready_reg  <= ready_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    gap_next    = gap_reg;
    idx_next    = idx_reg;
    resets_next = resets_reg;
    ready_next  = ready_reg;
    count_next  = count_reg;

    if ((state_reg != ST_HOLD) && abort) begin
      // Every domain is reasserted together; only a lock loss is counted,
      // and it still counts when a software request arrives in the same cycle.
      state_next  = ST_HOLD;
      hold_next   = '0;
      gap_next    = '0;
      idx_next    = '0;
      resets_next = '1;
      ready_next  = 1'b0;
      if (!locked_s && (count_reg != 8'hFF)) begin
        count_next = count_reg + 8'd1;
      end
    end else begin
      case (state_reg)
        ST_HOLD: begin
          resets_next = '1;
          ready_next  = 1'b0;
          gap_next    = '0;
          idx_next    = '0;
          if (abort) begin
            // Strict consecutive run: any gap in lock, or a software
            // request, starts the count over.
            hold_next = '0;
          end else if (hold_reg == HOLD_LAST) begin
            hold_next      = '0;
            resets_next[0] = 1'b0;
            if (NUM_RESETS == 1) begin
              state_next = ST_RUN;
              ready_next = 1'b1;
            end else begin
              state_next = ST_RELEASE;
              idx_next   = 4'd1;
            end
          end else begin
            hold_next = hold_reg + 16'd1;
          end
        end

        ST_RELEASE: begin
          if (gap_reg == GAP_LAST) begin
            resets_next = resets_reg & ~stage_sel;
            gap_next    = '0;
            idx_next    = idx_reg + 4'd1;
            if (idx_reg == IDX_LAST) begin
              state_next = ST_RUN;
              ready_next = 1'b1;
            end
          end else begin
            gap_next = gap_reg + 8'd1;
          end
        end

        ST_RUN: begin
          resets_next = '0;
          ready_next  = 1'b1;
        end

        default: begin
          state_next  = ST_HOLD;
          resets_next = '1;
          ready_next  = 1'b0;
        end
      endcase
    end
  end

  assign resets_out      = resets_reg;
  assign ready           = ready_reg;
  assign lock_loss_count = count_reg;

endmodule
